// File: rtl/player_pos_integrator.sv
// Player position integrator: accumulates per-frame signed X/Y steps into the
// sprite position, clamps to the playfield, flags ground/ceiling/wall contact
// and freezes the player for a fixed number of frames after a respawn.
// Optional build macro: PLAYER_POS_WRAP_X_EN (X wraps around instead of clamping).
module player_pos_integrator #(
    parameter logic [9:0] X_START        = 10'd320,
    parameter logic [9:0] Y_START        = 10'd400,
    parameter logic [9:0] X_MIN          = 10'd0,
    parameter logic [9:0] X_MAX          = 10'd631,
    parameter logic [9:0] Y_MIN          = 10'd16,
    parameter logic [9:0] GROUND_Y       = 10'd400,
    parameter logic [5:0] RESPAWN_FRAMES = 6'd30
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       frame_en,
    input  logic       Reset_New,
    input  logic [9:0] Ball_X_Move,
    input  logic [9:0] Ball_Y_Move,
    output logic [9:0] Ball_X_Pos,
    output logic [9:0] Ball_Y_Pos,
    output logic       Grd_hit,
    output logic       Land_p,
    output logic       Ceil_hit,
    output logic       Wall_hit,
    output logic       Frozen
);

    typedef enum logic [1:0] {StGrounded, StAirborne, StRespawn} state_e;

    // Positions are unsigned pixel coordinates, so they are zero-extended;
    // only the moves carry a sign.
    localparam logic signed [11:0] XMinS   = {2'b00, X_MIN};
    localparam logic signed [11:0] XMaxS   = {2'b00, X_MAX};
    localparam logic signed [11:0] YMinS   = {2'b00, Y_MIN};
    localparam logic signed [11:0] GroundS = {2'b00, GROUND_Y};
`ifdef PLAYER_POS_WRAP_X_EN
    // Wrap arithmetic is done modulo 1024; the low 10 bits come out right.
    localparam logic [9:0] XSpan = X_MAX - X_MIN + 10'd1;
`endif

    state_e      state_q, state_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        grd_q, grd_d, land_q, land_d, ceil_q, ceil_d, wall_q, wall_d;

    logic signed [11:0] x_sum, y_sum;
    logic [9:0]         x_new, y_new;
    logic               x_wall, y_ceil;

    // 12-bit sums followed by playfield clamp (or X wrap)
    always_comb begin
        x_sum  = $signed({2'b00, x_q}) + $signed({{2{Ball_X_Move[9]}}, Ball_X_Move});
        y_sum  = $signed({2'b00, y_q}) + $signed({{2{Ball_Y_Move[9]}}, Ball_Y_Move});
        x_new  = x_sum[9:0];
        x_wall = 1'b0;
`ifdef PLAYER_POS_WRAP_X_EN
        if (x_sum > XMaxS) begin
            x_new = x_sum[9:0] - XSpan;
        end else if (x_sum < XMinS) begin
            x_new = x_sum[9:0] + XSpan;
        end
`else
        if (x_sum > XMaxS) begin
            x_new  = X_MAX;
            x_wall = 1'b1;
        end else if (x_sum < XMinS) begin
            x_new  = X_MIN;
            x_wall = 1'b1;
        end
`endif
        y_new  = y_sum[9:0];
        y_ceil = 1'b0;
        if (y_sum > GroundS) begin
            y_new = GROUND_Y;
        end else if (y_sum < YMinS) begin
            y_new  = Y_MIN;
            y_ceil = 1'b1;
        end
    end

    // Next-state: respawn request beats frame update; pulses default low
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        grd_d   = grd_q;
        land_d  = 1'b0;
        ceil_d  = 1'b0;
        wall_d  = 1'b0;
        if (Reset_New) begin
            state_d = StRespawn;
            x_d     = X_START;
            y_d     = Y_START;
            cnt_d   = RESPAWN_FRAMES;
            grd_d   = 1'b1;
        end else if (frame_en) begin
            case (state_q)
                StRespawn: begin
                    // Leave on the frame that takes the counter to zero
                    if (cnt_q <= 6'd1) begin
                        cnt_d   = 6'd0;
                        state_d = StGrounded;
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
                default: begin
                    x_d    = x_new;
                    y_d    = y_new;
                    grd_d  = (y_new == GROUND_Y);
                    ceil_d = y_ceil;
                    wall_d = x_wall;
                    if (y_new == GROUND_Y) begin
                        state_d = StGrounded;
                        land_d  = (state_q == StAirborne);
                    end else begin
                        state_d = StAirborne;
                    end
                end
            endcase
        end
    end

    // State and output registers, synchronous active-high reset
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= StGrounded;
            x_q     <= X_START;
            y_q     <= Y_START;
            cnt_q   <= 6'd0;
            grd_q   <= 1'b1;
            land_q  <= 1'b0;
            ceil_q  <= 1'b0;
            wall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            grd_q   <= grd_d;
            land_q  <= land_d;
            ceil_q  <= ceil_d;
            wall_q  <= wall_d;
        end
    end

    assign Ball_X_Pos = x_q;
    assign Ball_Y_Pos = y_q;
    assign Grd_hit    = grd_q;
    assign Land_p     = land_q;
    assign Ceil_hit   = ceil_q;
    assign Wall_hit   = wall_q;
    assign Frozen     = (state_q == StRespawn);

endmodule

// File: tb/tb_player_pos_integrator.sv
// Bench for player_pos_integrator: a behavioural model predicts every cycle's
// outputs into a scoreboard queue, popped and compared after the clock edge,
// plus fixed-value checks at the key points of each scenario.
module tb_player_pos_integrator;

    logic       CLK = 1'b0;
    logic       Reset, frame_en, Reset_New;
    logic [9:0] Ball_X_Move, Ball_Y_Move;
    logic [9:0] Ball_X_Pos, Ball_Y_Pos;
    logic       Grd_hit, Land_p, Ceil_hit, Wall_hit, Frozen;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int x;
        int y;
        bit grd;
        bit land;
        bit ceil;
        bit wall;
        bit frz;
    } exp_t;

    exp_t exp_q[$];

    // Model state: st 0 = grounded, 1 = airborne, 2 = respawn
    int m_x, m_y, m_st, m_cnt;
    bit m_grd;

    player_pos_integrator dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .frame_en    (frame_en),
        .Reset_New   (Reset_New),
        .Ball_X_Move (Ball_X_Move),
        .Ball_Y_Move (Ball_Y_Move),
        .Ball_X_Pos  (Ball_X_Pos),
        .Ball_Y_Pos  (Ball_Y_Pos),
        .Grd_hit     (Grd_hit),
        .Land_p      (Land_p),
        .Ceil_hit    (Ceil_hit),
        .Wall_hit    (Wall_hit),
        .Frozen      (Frozen)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Drive one cycle, predict, then compare the popped prediction after the edge
    task automatic cyc(input bit rst, input bit rn, input bit fe, input int xm, input int ym);
        exp_t e;
        int   nx, ny;
        Reset       = rst;
        Reset_New   = rn;
        frame_en    = fe;
        Ball_X_Move = xm[9:0];
        Ball_Y_Move = ym[9:0];
        e.land = 0;
        e.ceil = 0;
        e.wall = 0;
        if (rst) begin
            m_x = 320; m_y = 400; m_st = 0; m_cnt = 0; m_grd = 1;
        end else if (rn) begin
            m_x = 320; m_y = 400; m_st = 2; m_cnt = 30; m_grd = 1;
        end else if (fe) begin
            if (m_st == 2) begin
                m_cnt--;
                if (m_cnt <= 0) m_st = 0;
            end else begin
                nx = m_x + xm;
`ifdef PLAYER_POS_WRAP_X_EN
                if (nx > 631) nx = nx - 632;
                else if (nx < 0) nx = nx + 632;
`else
                if (nx > 631) begin nx = 631; e.wall = 1; end
                else if (nx < 0) begin nx = 0; e.wall = 1; end
`endif
                ny = m_y + ym;
                if (ny > 400) ny = 400;
                else if (ny < 16) begin ny = 16; e.ceil = 1; end
                e.land = (m_st == 1) && (ny == 400);
                m_st   = (ny == 400) ? 0 : 1;
                m_x    = nx;
                m_y    = ny;
                m_grd  = (ny == 400);
            end
        end
        e.x   = m_x;
        e.y   = m_y;
        e.grd = m_grd;
        e.frz = (m_st == 2);
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        Reset     = 1'b0;
        Reset_New = 1'b0;
        frame_en  = 1'b0;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("x",      {22'd0, Ball_X_Pos}, e.x);
            chk("y",      {22'd0, Ball_Y_Pos}, e.y);
            chk("grd",    {31'd0, Grd_hit},    {31'd0, e.grd});
            chk("land",   {31'd0, Land_p},     {31'd0, e.land});
            chk("ceil",   {31'd0, Ceil_hit},   {31'd0, e.ceil});
            chk("wall",   {31'd0, Wall_hit},   {31'd0, e.wall});
            chk("frozen", {31'd0, Frozen},     {31'd0, e.frz});
        end
    endtask

    task automatic frame(input int xm, input int ym);
        cyc(1'b0, 1'b0, 1'b1, xm, ym);
    endtask

    // Non-frame cycle with junk moves that must be ignored
    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 5, -3);
    endtask

    initial begin
        Reset = 1'b1; Reset_New = 1'b0; frame_en = 1'b0;
        Ball_X_Move = '0; Ball_Y_Move = '0;
        m_x = 320; m_y = 400; m_st = 0; m_cnt = 0; m_grd = 1;

        // Reset, including reset winning over a coincident frame
        cyc(1'b1, 1'b0, 1'b0, 0, 0);
        cyc(1'b1, 1'b0, 1'b1, 50, -50);

        // 1. Idle frames from reset
        repeat (5) begin
            frame(0, 0);
            chk("idle_land", {31'd0, Land_p}, 32'd0);
            idle();
        end
        chk("idle_x", {22'd0, Ball_X_Pos}, 32'd320);
        chk("idle_y", {22'd0, Ball_Y_Pos}, 32'd400);
        chk("idle_grd", {31'd0, Grd_hit}, 32'd1);

        // 2. Jump and land
        frame(0, -7);
        chk("jump_y1", {22'd0, Ball_Y_Pos}, 32'd393);
        chk("jump_grd1", {31'd0, Grd_hit}, 32'd0);
        idle();
        for (int i = 2; i <= 8; i++) begin
            frame(0, 1);
            if (i < 8) idle();
        end
        chk("jump_y8", {22'd0, Ball_Y_Pos}, 32'd400);
        chk("jump_land8", {31'd0, Land_p}, 32'd1);
        idle();
        chk("jump_land_drop", {31'd0, Land_p}, 32'd0);

        // 3. Overshoot below ground clamps and lands
        frame(0, -2);
        chk("over_y398", {22'd0, Ball_Y_Pos}, 32'd398);
        frame(0, 5);
        chk("over_y", {22'd0, Ball_Y_Pos}, 32'd400);
        chk("over_land", {31'd0, Land_p}, 32'd1);
        idle();

        // 4. X clamp / wrap at the edges
        frame(309, 0);
        chk("x629", {22'd0, Ball_X_Pos}, 32'd629);
        frame(4, 0);
`ifdef PLAYER_POS_WRAP_X_EN
        chk("xwrap_hi", {22'd0, Ball_X_Pos}, 32'd1);
        chk("xwrap_wall", {31'd0, Wall_hit}, 32'd0);
`else
        chk("xclamp_hi", {22'd0, Ball_X_Pos}, 32'd631);
        chk("xclamp_wall", {31'd0, Wall_hit}, 32'd1);
`endif
        idle();
        frame(-300, 0);
        frame(2 - m_x, 0);
        chk("x2", {22'd0, Ball_X_Pos}, 32'd2);
        frame(-4, 0);
`ifndef PLAYER_POS_WRAP_X_EN
        chk("xclamp_lo", {22'd0, Ball_X_Pos}, 32'd0);
        chk("xclamp_lo_wall", {31'd0, Wall_hit}, 32'd1);
`endif
        frame(-4, 0);
        idle();

        // 5. Respawn coincident with a frame and a jump
        frame(-(m_x / 2), 0);
        frame(100 - m_x, 0);
        chk("x100", {22'd0, Ball_X_Pos}, 32'd100);
        cyc(1'b0, 1'b1, 1'b1, 0, -7);
        chk("resp_x", {22'd0, Ball_X_Pos}, 32'd320);
        chk("resp_y", {22'd0, Ball_Y_Pos}, 32'd400);
        chk("resp_frz", {31'd0, Frozen}, 32'd1);
        for (int i = 1; i <= 30; i++) begin
            frame(37, -7);
            if (i == 29) chk("resp_frz29", {31'd0, Frozen}, 32'd1);
            if (i == 30) chk("resp_frz30", {31'd0, Frozen}, 32'd0);
            idle();
        end
        frame(5, 0);
        chk("post_resp_x", {22'd0, Ball_X_Pos}, 32'd325);

        // Respawn reload mid-respawn
        cyc(1'b0, 1'b1, 1'b0, 0, 0);
        repeat (5) frame(9, 9);
        cyc(1'b0, 1'b1, 1'b0, 0, 0);
        repeat (29) frame(1, -1);
        chk("reload_frz29", {31'd0, Frozen}, 32'd1);
        frame(1, -1);
        chk("reload_frz30", {31'd0, Frozen}, 32'd0);

        // 6. Ceiling clamp, then reset mid-flight
        frame(0, -380);
        chk("y20", {22'd0, Ball_Y_Pos}, 32'd20);
        frame(0, -7);
        chk("ceil_y", {22'd0, Ball_Y_Pos}, 32'd16);
        chk("ceil_hit", {31'd0, Ceil_hit}, 32'd1);
        idle();
        chk("ceil_drop", {31'd0, Ceil_hit}, 32'd0);
        frame(3, 2);
        cyc(1'b1, 1'b0, 1'b1, 10, 10);
        chk("rst_x", {22'd0, Ball_X_Pos}, 32'd320);
        chk("rst_y", {22'd0, Ball_Y_Pos}, 32'd400);
        chk("rst_grd", {31'd0, Grd_hit}, 32'd1);
        frame(0, 0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
